// File: rtl/bcd_countdown_timer_pkg.sv
// Shared types and constants for the BCD countdown timer: FSM states and
// per-digit wrap values used by the borrow chain.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } timer_state_t;

    localparam int BCD_MAX_UNITS    = 9;
    localparam int BCD_MAX_TENS_SEC = 5;

    // Keypad codes above 9 are not decimal digits and must not enter the register.
    function automatic logic bcd_valid(input logic [3:0] d);
        return d <= 4'd9;
    endfunction

endpackage

// File: rtl/bcd_countdown_timer_if.sv
// Keypad/controller side bundle of the countdown timer: entry and control
// strobes towards the timer, digits and status back.
interface bcd_countdown_timer_if #(
    parameter int MIN_DIGITS = 1
);
    localparam int DW = 4 * (MIN_DIGITS + 2);

    logic          load;
    logic [3:0]    bcd_input;
    logic          start;
    logic          pause;
    logic          cancel;
    logic [DW-1:0] bcd_output;
    logic          running;
    logic          paused;
    logic          zero;
    logic          done;

    modport master (
        output load, bcd_input, start, pause, cancel,
        input  bcd_output, running, paused, zero, done
    );

    modport slave (
        input  load, bcd_input, start, pause, cancel,
        output bcd_output, running, paused, zero, done
    );

endinterface

// File: rtl/bcd_countdown_timer_bcd_down_digit.sv
// One BCD down-counting digit: parallel load has priority over decrement,
// and a decrement from 0 wraps to MAX while raising borrow_out.
module bcd_down_digit #(
    parameter int MAX = 9
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       dec_en,
    input  logic       load_en,
    input  logic [3:0] load_val,
    output logic [3:0] digit,
    output logic       borrow_out,
    output logic       is_zero
);

    localparam logic [3:0] MAX_V = 4'(MAX);

    logic [3:0] digit_reg;

    always_ff @(posedge clk) begin
        if (clear) begin
            digit_reg <= 4'd0;
        end else if (load_en) begin
            digit_reg <= load_val;
        end else if (dec_en) begin
            digit_reg <= (digit_reg == 4'd0) ? MAX_V : digit_reg - 4'd1;
        end
    end

    assign digit      = digit_reg;
    assign is_zero    = (digit_reg == 4'd0);
    assign borrow_out = is_zero && dec_en;

endmodule

// File: rtl/bcd_countdown_timer.sv
// Microwave BCD countdown timer: keypad shift-in entry, run/pause control,
// built-in one-second prescaler and a one-cycle done pulse at 00:00.
module bcd_countdown_timer
    import timer_pkg::*;
#(
    parameter int MIN_DIGITS = 1,
    parameter int TICK_DIV   = 50_000_000
) (
    input  logic               clk,
    input  logic               clear,
    bcd_countdown_timer_if.slave bus
);

    localparam int ND = MIN_DIGITS + 2;
    localparam int DW = 4 * ND;
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    timer_state_t  state_reg;
    logic [PW-1:0] presc_reg;
    logic          running_reg;
    logic          paused_reg;
    logic          done_reg;

    logic [ND-1:0][3:0] digits;
    logic [ND-1:0]      dig_zero;
    logic [ND-1:0]      borrow;
    logic [DW-1:0]      digits_flat;

    logic zero;
    logic entry_state;
    logic tick;
    logic tick_dec;
    logic terminal;
    logic floor_hit;
    logic pause_act;
    logic start_act;
    logic load_act;
    logic digit_load;
    logic load_zero;

    // Resolve the strobes in priority order: cancel > pause > start > load.
    always_comb begin
        zero        = &dig_zero;
        entry_state = (state_reg == IDLE) || (state_reg == DONE);
        tick        = (state_reg == RUN) && (presc_reg == PRESC_LAST);
        tick_dec    = tick && !bus.cancel;
        terminal    = (digits[0] == 4'd1) && (&dig_zero[ND-1:1]);
        floor_hit   = borrow[ND-1];
        pause_act   = !bus.cancel && bus.pause && (state_reg == RUN);
        start_act   = !bus.cancel && !pause_act && bus.start &&
                      ((entry_state && !zero) || (state_reg == PAUSE));
        load_act    = !bus.cancel && !start_act && bus.load && entry_state &&
                      bcd_valid(bus.bcd_input);
        // A borrow out of the top digit means the register was already zero:
        // reload zeros instead of wrapping to 99:59.
        load_zero   = bus.cancel || floor_hit;
        digit_load  = load_zero || load_act;
    end

    for (genvar gi = 0; gi < ND; gi++) begin : g_digit
        localparam int DMAX = (gi == 1) ? BCD_MAX_TENS_SEC : BCD_MAX_UNITS;

        logic [3:0] shift_in;
        logic       dec_in;

        if (gi == 0) begin : g_lsd
            assign shift_in = bus.bcd_input;
            assign dec_in   = tick_dec;
        end else begin : g_upper
            assign shift_in = digits[gi-1];
            assign dec_in   = borrow[gi-1];
        end

        bcd_down_digit #(
            .MAX(DMAX)
        ) u_digit (
            .clk       (clk),
            .clear     (clear),
            .dec_en    (dec_in),
            .load_en   (digit_load),
            .load_val  (load_zero ? 4'd0 : shift_in),
            .digit     (digits[gi]),
            .borrow_out(borrow[gi]),
            .is_zero   (dig_zero[gi])
        );
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_reg   <= IDLE;
            presc_reg   <= '0;
            running_reg <= 1'b0;
            paused_reg  <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (bus.cancel) begin
                state_reg   <= IDLE;
                presc_reg   <= '0;
                running_reg <= 1'b0;
                paused_reg  <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE, DONE: begin
                        if (start_act) begin
                            state_reg   <= RUN;
                            presc_reg   <= '0;
                            running_reg <= 1'b1;
                            paused_reg  <= 1'b0;
                        end else if (load_act) begin
                            state_reg <= IDLE;
                        end
                    end
                    RUN: begin
                        // The prescaler advances on every RUN cycle, including
                        // the one in which pause is sampled.
                        presc_reg <= tick ? '0 : presc_reg + PW'(1);
                        if (tick && terminal) begin
                            state_reg   <= DONE;
                            running_reg <= 1'b0;
                            done_reg    <= 1'b1;
                        end else if (pause_act) begin
                            state_reg   <= PAUSE;
                            running_reg <= 1'b0;
                            paused_reg  <= 1'b1;
                        end
                    end
                    PAUSE: begin
                        if (start_act) begin
                            state_reg   <= RUN;
                            running_reg <= 1'b1;
                            paused_reg  <= 1'b0;
                        end
                    end
                    default: begin
                        state_reg   <= IDLE;
                        running_reg <= 1'b0;
                        paused_reg  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign digits_flat    = digits;
    assign bus.bcd_output = digits_flat;
    assign bus.running    = running_reg;
    assign bus.paused     = paused_reg;
    assign bus.zero       = zero;
    assign bus.done       = done_reg;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Scoreboard bench for bcd_countdown_timer (MIN_DIGITS=1, TICK_DIV=4): stimulus
// queues expected outputs by cycle, a monitor pops and compares them.
module tb_bcd_countdown_timer;

    localparam int MIN_DIGITS = 1;
    localparam int TICK_DIV   = 4;

    logic clk   = 1'b0;
    logic clear = 1'b1;

    always #5 clk = ~clk;

    bcd_countdown_timer_if #(.MIN_DIGITS(MIN_DIGITS)) bus();

    bcd_countdown_timer #(
        .MIN_DIGITS(MIN_DIGITS),
        .TICK_DIV  (TICK_DIV)
    ) dut (
        .clk  (clk),
        .clear(clear),
        .bus  (bus)
    );

    typedef struct {
        int          target;
        logic [11:0] out;
        logic        run;
        logic        pau;
        logic        zer;
        logic        dn;
    } exp_t;

    exp_t  sb[$];
    string sb_name[$];
    int    cyc       = 0;
    int    errors    = 0;
    int    checks    = 0;
    int    done_seen = 0;
    int    done_exp  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Expected state after posedge number cyc+d, kept sorted by target cycle.
    task automatic expect_at(input int d, input string name, input logic [11:0] out,
                             input logic run, input logic pau, input logic zer, input logic dn);
        exp_t e;
        int   i;
        e.target = cyc + d;
        e.out    = out;
        e.run    = run;
        e.pau    = pau;
        e.zer    = zer;
        e.dn     = dn;
        i = sb.size();
        while (i > 0 && sb[i-1].target > e.target) i--;
        sb.insert(i, e);
        sb_name.insert(i, name);
    endtask

    task automatic step(input logic ld, input logic [3:0] din, input logic st,
                        input logic pa, input logic ca);
        bus.load      = ld;
        bus.bcd_input = din;
        bus.start     = st;
        bus.pause     = pa;
        bus.cancel    = ca;
        @(negedge clk);
        bus.load   = 1'b0;
        bus.start  = 1'b0;
        bus.pause  = 1'b0;
        bus.cancel = 1'b0;
    endtask

    task automatic load_digit(input logic [3:0] d);
        step(1'b1, d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: compares every expectation due at this cycle, 1 time unit after the edge.
    initial begin
        exp_t  e;
        string nm;
        forever begin
            @(posedge clk);
            #1;
            if (bus.done) done_seen++;
            while (sb.size() > 0 && sb[0].target <= cyc) begin
                e  = sb.pop_front();
                nm = sb_name.pop_front();
                checks++;
                if (e.target < cyc) begin
                    errors++;
                    $display("FAIL %s: check cycle %0d was missed, now at %0d", nm, e.target, cyc);
                end else if (bus.bcd_output !== e.out || bus.running !== e.run ||
                             bus.paused !== e.pau || bus.zero !== e.zer || bus.done !== e.dn) begin
                    errors++;
                    $display("FAIL %s: got out=%03h run=%b paused=%b zero=%b done=%b, want out=%03h run=%b paused=%b zero=%b done=%b",
                             nm, bus.bcd_output, bus.running, bus.paused, bus.zero, bus.done,
                             e.out, e.run, e.pau, e.zer, e.dn);
                end else begin
                    $display("ok   %s: out=%03h run=%b paused=%b zero=%b done=%b",
                             nm, bus.bcd_output, bus.running, bus.paused, bus.zero, bus.done);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached with %0d checks pending", sb.size());
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.load      = 1'b0;
        bus.bcd_input = 4'd0;
        bus.start     = 1'b0;
        bus.pause     = 1'b0;
        bus.cancel    = 1'b0;
        clear         = 1'b1;
        idle(3);
        expect_at(1, "reset", 12'h000, 0, 0, 1, 0);
        idle(1);
        clear = 1'b0;
        idle(1);

        // Keypad entry
        expect_at(1, "entry_1", 12'h001, 0, 0, 0, 0);
        load_digit(4'd1);
        expect_at(1, "entry_13", 12'h013, 0, 0, 0, 0);
        load_digit(4'd3);
        expect_at(1, "entry_130", 12'h130, 0, 0, 0, 0);
        load_digit(4'd0);
        expect_at(1, "entry_bad_digit", 12'h130, 0, 0, 0, 0);
        load_digit(4'hA);
        expect_at(1, "cancel_idle", 12'h000, 0, 0, 1, 0);
        step(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);

        // Full countdown 0:12 -> 0:00
        load_digit(4'd0);
        load_digit(4'd1);
        expect_at(1, "cd_entry", 12'h012, 0, 0, 0, 0);
        load_digit(4'd2);
        expect_at(1,  "cd_start",      12'h012, 1, 0, 0, 0);
        expect_at(5,  "cd_tick1",      12'h011, 1, 0, 0, 0);
        expect_at(9,  "cd_tick2",      12'h010, 1, 0, 0, 0);
        expect_at(13, "cd_tick3",      12'h009, 1, 0, 0, 0);
        expect_at(48, "cd_last_sec",   12'h001, 1, 0, 0, 0);
        expect_at(49, "cd_done",       12'h000, 0, 0, 1, 1);
        expect_at(50, "cd_done_clear", 12'h000, 0, 0, 1, 0);
        done_exp++;
        step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        idle(50);

        // Pause / resume with preserved prescaler
        expect_at(1, "pr_load_from_done", 12'h005, 0, 0, 0, 0);
        load_digit(4'd5);
        expect_at(1,  "pr_run",    12'h005, 1, 0, 0, 0);
        expect_at(3,  "pr_paused", 12'h005, 0, 1, 0, 0);
        expect_at(13, "pr_hold",   12'h005, 0, 1, 0, 0);
        step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        idle(1);
        step(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        idle(10);
        expect_at(1, "pr_resume",        12'h005, 1, 0, 0, 0);
        expect_at(2, "pr_no_early_tick", 12'h005, 1, 0, 0, 0);
        expect_at(3, "pr_tick",          12'h004, 1, 0, 0, 0);
        step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        idle(2);
        expect_at(1, "pr_cancel", 12'h000, 0, 0, 1, 0);
        step(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);

        // "99" seconds entry counts down decimally
        load_digit(4'd9);
        expect_at(1, "b99_entry", 12'h099, 0, 0, 0, 0);
        load_digit(4'd9);
        expect_at(5,  "b99_t1",  12'h098, 1, 0, 0, 0);
        expect_at(37, "b99_t9",  12'h090, 1, 0, 0, 0);
        expect_at(41, "b99_t10", 12'h089, 1, 0, 0, 0);
        step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        idle(40);
        expect_at(1, "b99_cancel", 12'h000, 0, 0, 1, 0);
        step(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);

        // 1:00 borrows through seconds tens to 0:59
        load_digit(4'd1);
        load_digit(4'd0);
        expect_at(1, "b100_entry", 12'h100, 0, 0, 0, 0);
        load_digit(4'd0);
        expect_at(1, "b100_run",  12'h100, 1, 0, 0, 0);
        expect_at(4, "b100_pre",  12'h100, 1, 0, 0, 0);
        expect_at(5, "b100_tick", 12'h059, 1, 0, 0, 0);
        step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        idle(4);
        expect_at(1, "b100_cancel", 12'h000, 0, 0, 1, 0);
        step(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);

        // start with all-zero digits is ignored
        expect_at(1, "zero_start",      12'h000, 0, 0, 1, 0);
        expect_at(5, "zero_start_hold", 12'h000, 0, 0, 1, 0);
        step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        idle(4);

        // Strobe priority
        load_digit(4'd3);
        expect_at(1, "pri_entry", 12'h030, 0, 0, 0, 0);
        load_digit(4'd0);
        expect_at(1, "pri_run",          12'h030, 1, 0, 0, 0);
        expect_at(2, "pri_start_pause",  12'h030, 0, 1, 0, 0);
        expect_at(3, "pri_resume",       12'h030, 1, 0, 0, 0);
        expect_at(4, "pri_cancel_pause", 12'h000, 0, 0, 1, 0);
        expect_at(8, "pri_cancel_hold",  12'h000, 0, 0, 1, 0);
        step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
        idle(5);

        // Reset mid-RUN; load while running is ignored
        load_digit(4'd4);
        expect_at(1, "rst_entry", 12'h042, 0, 0, 0, 0);
        load_digit(4'd2);
        expect_at(1, "rst_run",          12'h042, 1, 0, 0, 0);
        expect_at(2, "rst_load_ignored", 12'h042, 1, 0, 0, 0);
        expect_at(3, "rst_clear",        12'h000, 0, 0, 1, 0);
        expect_at(7, "rst_idle_hold",    12'h000, 0, 0, 1, 0);
        step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 4'd7, 1'b0, 1'b0, 1'b0);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        idle(6);

        for (int i = 0; i < 100 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations never reached, want 0", sb.size());
        end

        checks++;
        if (done_seen != done_exp) begin
            errors++;
            $display("FAIL done_count: got %0d done pulses, want %0d", done_seen, done_exp);
        end else begin
            $display("ok   done_count: %0d done pulses", done_seen);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bcd_countdown_timer.md
Name: bcd_countdown_timer

Overview:
- Parametrised BCD countdown timer for the microwave controller: MM…M:SS display digits, keypad shift-in entry, start/pause/resume/cancel control, built-in 1 Hz prescaler, one-cycle done pulse.
- Sits between the keypad decoder and the display/magnetron control FSM.
- Generalises the fixed 1-minute-digit timer:
  - configurable minute-digit count and tick rate;
  - explicit run/pause state.

Parameters:
- MIN_DIGITS, 1, number of BCD minute digits (1..4).
- TICK_DIV, 50_000_000, clk cycles per one-second decrement (≥2).
- DW, 4*(MIN_DIGITS+2), derived total BCD bus width (localparam, not overridable).

Ports:
- clk  in  1  system clock, all logic on rising edge
- clear  in  1  synchronous active-high reset
- load  in  1  one-cycle strobe: shift bcd_input into the digit register
- bcd_input  in  4  keypad digit, valid with load
- start  in  1  one-cycle strobe: begin or resume countdown
- pause  in  1  one-cycle strobe: suspend countdown
- cancel  in  1  one-cycle strobe: abort, zero digits
- bcd_output  out  DW  digits, [3:0]=sec units, [7:4]=sec tens, [DW-1:8]=minutes (LS minute lowest)
- running  out  1  high in RUN
- paused  out  1  high in PAUSE
- zero  out  1  all digits zero (combinational on digit register)
- done  out  1  one-cycle pulse when countdown reaches 00:00

Behaviour:
- Reset: synchronous and active-high; clk is the only clock. On clear (highest priority): state=IDLE, digits=0, prescaler=0, done=0, running=0, paused=0.
- States:
  - IDLE: entry allowed.
  - RUN: counting.
  - PAUSE: frozen, prescaler held.
  - DONE: reached zero.
- Priority within a cycle: clear > cancel > pause > start > load.
- load:
  - Accepted only in IDLE or DONE; in DONE it also moves state to IDLE.
  - Digits shift left one nibble: bcd_input enters sec units; top minute digit is discarded.
  - bcd_input > 9 is ignored (no shift).
  - Ignored in RUN/PAUSE.
- start:
  - IDLE/DONE with zero=0 → RUN, prescaler reset to 0.
  - IDLE/DONE with zero=1 → ignored.
  - PAUSE → RUN, prescaler keeps its value.
  - RUN → no effect.
- pause: RUN → PAUSE; no effect elsewhere. start+pause in the same RUN cycle → PAUSE.
- cancel: any state → IDLE, digits=0, prescaler=0; no done pulse.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RUN.
  - tick when count==TICK_DIV-1. First decrement occurs TICK_DIV cycles after start is sampled.
- Decrement on tick, as a BCD borrow chain:
  - sec units 0→9 borrows;
  - sec tens 0→5 borrows;
  - each minute digit 0→9 borrows to the next.
- Entered sec tens 6..9 (e.g. "99" seconds): decremented normally (9→8…). This allows 99 s entry; no normalisation is applied.
- Terminal condition:
  - On the tick where the pre-decrement value equals 00:01, digits become 0, state → DONE, done=1 for exactly that next cycle.
  - Digits never wrap below zero.
- running and paused are registered, updated with the state.
- Reset mid-RUN: same as the reset values above; no done pulse.

Decomposition:
- Shared package timer_pkg: state enum (IDLE, RUN, PAUSE, DONE), BCD_MAX_UNITS=9, BCD_MAX_TENS_SEC=5.
- One sub-module, bcd_down_digit (params MAX):
  - inputs: dec_en, load_en, load_val;
  - outputs: digit, borrow_out (digit==0 && dec_en), is_zero.
- The top instantiates MIN_DIGITS+2 of these in a generate loop, plus the FSM and prescaler.

Test Plan (bench: MIN_DIGITS=1, TICK_DIV=4):
- Entry: clear, load 1, 3, 0 → bcd_output=0x130, zero=0. Then load 0xA → unchanged.
- Countdown: entry 0,1,2 then start → 0x011 after 4 cycles, 0x010 after 8, 0x009 after 12. Continue until 0x000, then check done=1 exactly one cycle, running=0, state DONE.
- Pause/resume: start from 0x005, pause 2 cycles after start, hold 10 cycles → value stays 0x005. Then start → first decrement 2 cycles later (prescaler preserved).
- Boundary: "99" s entry 0x099 → counts 098…090, 089. Entry 0x100 → next tick 0x059. start with 0x000 → stays IDLE, running=0.
- Priority: in RUN, assert start+pause together → PAUSE. Assert cancel+pause → IDLE, digits 0, no done pulse.
- Reset: assert clear mid-RUN at 0x042 → next cycle all outputs 0, state IDLE. A load during RUN is ignored.
